ahb2apb_bridge: RTL

AHB2APB_BRIDGE -- requirements
Module: ahb2apb_bridge

---
 rtl/ahb2apb_bridge.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge. Each accepted AHB transfer becomes
// exactly one APB transfer. Every bus-facing output comes straight from a flop.
module ahb2apb_bridge #(
  parameter int AHB_BUS_W  = 32,
  parameter int AHB_ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  // AHB slave side
  input  logic                     hsel,
  input  logic [AHB_ADDR_W-1:0]    haddr,
  input  logic [1:0]               htrans,
  input  logic                     hwrite,
  input  logic [2:0]               hsize,
  input  logic [2:0]               hburst,
  input  logic [AHB_BUS_W-1:0]     hwdata,
  output logic [AHB_BUS_W-1:0]     hrdata,
  output logic                     hready,
  // APB master side
  output logic [AHB_ADDR_W-1:0]    paddr,
  output logic [AHB_BUS_W-1:0]     pwdata,
  output logic [AHB_BUS_W/8-1:0]   pstrb,
  output logic                     pwrite,
  output logic                     psel,
  output logic                     penable,
  input  logic [AHB_BUS_W-1:0]     prdata,
  input  logic                     pready,
  // FSM state: 0 IDLE, 1 WDATA, 2 SETUP, 3 ACCESS, 4 DONE
  output logic [2:0]               dbg_state
);

  localparam int NBYTES = AHB_BUS_W / 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WDATA  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic [2:0]        lane;
  logic [NBYTES-1:0] strb_calc;
  int                size_bytes;
  int                lane_base;
  logic              unused_ok;

  // Handshakes: an AHB address phase is taken only while hready is high
  // (IDLE/DONE) with hsel and a NONSEQ/SEQ htrans; a low hready stretches the
  // data phase and the master holds its signals. On APB, psel rises for one
  // SETUP cycle, then penable joins it and both hold until pready is high.
  assign accept    = ((state == S_IDLE) || (state == S_DONE)) && hsel && htrans[1];
  assign lane      = haddr[2:0];
  assign dbg_state = state;
  assign unused_ok = ^{hburst, htrans[0]};

  // Write strobe: 2^hsize lanes from the size-aligned byte offset, or every
  // lane once the transfer is at least as wide as the bus.
  always_comb begin
    strb_calc  = '0;
    size_bytes = 1 << hsize;
    lane_base  = int'(lane) & (NBYTES - 1) & ~(size_bytes - 1);
    for (int i = 0; i < NBYTES; i++) begin
      if ((size_bytes >= NBYTES) ||
          ((i >= lane_base) && (i < lane_base + size_bytes))) begin
        strb_calc[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_next = hwrite ? S_WDATA : S_SETUP;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_WDATA:  state_next = S_SETUP;
      S_SETUP:  state_next = S_ACCESS;
      S_ACCESS: begin
        if (pready) begin
          state_next = S_DONE;
        end
      end
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Status outputs are registered from the next state so they line up with
  // the state they describe without any combinational decode on the ports.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hready  <= 1'b1;
      psel    <= 1'b0;
      penable <= 1'b0;
      paddr   <= '0;
      pwrite  <= 1'b0;
      pstrb   <= '0;
      pwdata  <= '0;
      hrdata  <= '0;
    end else begin
      hready  <= (state_next == S_IDLE) || (state_next == S_DONE);
      psel    <= (state_next == S_SETUP) || (state_next == S_ACCESS);
      penable <= (state_next == S_ACCESS);
      if (accept) begin
        paddr  <= haddr;
        pwrite <= hwrite;
        pstrb  <= hwrite ? strb_calc : '0;
      end
      if (state == S_WDATA) begin
        pwdata <= hwdata;
      end
      if ((state == S_ACCESS) && pready && !pwrite) begin
        hrdata <= prdata;
      end
    end
  end

endmodule
